// File: rtl/tlc_state_sequencer_if.sv
// Signal bundle between the Mk1 input logic and the state sequencer.
// The sequencer sits on the slave side; the input logic (or a bench) is the master.
interface tlc_state_sequencer_if;
    logic [3:0] x;       // next state from input logic
    logic       sensor;  // raw side-street car sensor, asynchronous
    logic [3:0] y;       // registered current state
    logic       w;       // latched car request
    logic       adv;     // one-cycle pulse aligned with a new y
    logic [7:0] remain;  // ticks left in the current state

    modport master (
        output x,
        output sensor,
        input  y,
        input  w,
        input  adv,
        input  remain
    );

    modport slave (
        input  x,
        input  sensor,
        output y,
        output w,
        output adv,
        output remain
    );
endinterface

// File: rtl/tlc_state_sequencer.sv
// State register and timing stage of the Mk1 traffic light controller.
// Holds the current state y, loads the next state x only when the dwell
// for the current state runs out, and turns the raw car sensor into the
// latched request w.
module tlc_state_sequencer #(
    parameter int TICK_DIV  = 50_000_000,  // clocks per 1 s tick, >= 2
    parameter int LONG_SEC  = 10,          // dwell for states with y[0]==0
    parameter int SHORT_SEC = 3            // dwell for states with y[0]==1
) (
    input  logic                  clk,
    input  logic                  rst,
    tlc_state_sequencer_if.slave  bus
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    // Dwell length in ticks is chosen by the low bit of the state code:
    // even codes are the long green/red phases, odd codes the short ones.
    function automatic logic [7:0] dwell(input logic [3:0] s);
        return s[0] ? 8'(SHORT_SEC) : 8'(LONG_SEC);
    endfunction

    logic [PW-1:0] pre;
    logic          tick;
    logic          advance;
    logic [2:0]    sync_pipe;  // [0],[1] synchronizer, [2] previous synced value
    logic          rise;
    logic [3:0]    y_q;
    logic          w_q;
    logic          adv_q;
    logic [7:0]    remain_q;

    assign tick    = (pre == PRE_MAX);
    // remain never sits at 0, so reaching 1 on a tick means the dwell is over
    assign advance = tick && (remain_q == 8'd1);
    assign rise    = sync_pipe[1] & ~sync_pipe[2];

    // Free-running prescaler; deliberately not restarted on advance so the
    // tick grid stays fixed relative to reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + 1'b1;
    end

    // Two-FF synchronizer plus one more stage holding the last synced value
    // for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_pipe <= '0;
        else     sync_pipe <= {sync_pipe[1:0], bus.sensor};
    end

    // State register and dwell countdown; x is only looked at on advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q      <= 4'd0;
            remain_q <= 8'(LONG_SEC);
            adv_q    <= 1'b0;
        end else begin
            adv_q <= advance;
            if (advance) begin
                y_q      <= bus.x;
                remain_q <= dwell(bus.x);
            end else if (tick) begin
                remain_q <= remain_q - 8'd1;
            end
        end
    end

    // Car request: a new synced edge sets it, an advance clears it, and a
    // set in the advance cycle survives into the new state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          w_q <= 1'b0;
        else if (rise)    w_q <= 1'b1;
        else if (advance) w_q <= 1'b0;
    end

    assign bus.y      = y_q;
    assign bus.w      = w_q;
    assign bus.adv    = adv_q;
    assign bus.remain = remain_q;

endmodule

// File: tb/tb_tlc_state_sequencer.sv
// Bench for tlc_state_sequencer: directed scenarios with hand-computed
// values, then randomized x/sensor/reset traffic against a behavioural model.
module tb_tlc_state_sequencer;

    localparam int TD = 4;
    localparam int LS = 3;
    localparam int SS = 1;

    logic clk;
    logic rst;
    tlc_state_sequencer_if bus();

    tlc_state_sequencer #(.TICK_DIV(TD), .LONG_SEC(LS), .SHORT_SEC(SS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time is tracked as the number of clock edges since reset release; a
    // tick lands on every TD-th edge. The synced sensor seen at an edge is
    // the sample taken two edges earlier, compared with the one three back.
    int         m_edges;
    int         m_rem;
    logic [3:0] m_y;
    logic       m_w;
    logic       m_adv;
    bit         samples[$];

    function automatic int dwell_of(input logic [3:0] s);
        return s[0] ? SS : LS;
    endfunction

    function automatic bit past(input int k);
        if (samples.size() >= k) return samples[samples.size() - k];
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_edges = 0;
            m_rem   = LS;
            m_y     = 4'd0;
            m_w     = 1'b0;
            m_adv   = 1'b0;
            samples.delete();
        end else begin
            bit tick, rise;
            m_edges++;
            tick = (m_edges % TD) == 0;
            rise = past(2) && !past(3);
            samples.push_back(bus.sensor);
            if (samples.size() > 8) void'(samples.pop_front());
            m_adv = tick && (m_rem == 1);
            if (m_adv) begin
                m_y   = bus.x;
                m_rem = dwell_of(bus.x);
            end else if (tick) begin
                m_rem = m_rem - 1;
            end
            if (rise)       m_w = 1'b1;
            else if (m_adv) m_w = 1'b0;
        end
    end

    // Compare every cycle, shortly after the active edge.
    always @(posedge clk) begin
        #1;
        chk("model_y",      int'(bus.y),      int'(m_y));
        chk("model_w",      int'(bus.w),      int'(m_w));
        chk("model_adv",    int'(bus.adv),    int'(m_adv));
        chk("model_remain", int'(bus.remain), m_rem);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        bus.x      = 4'h2;
        bus.sensor = 1'b0;
        cyc(3);
        chk("rst_y",      int'(bus.y),      0);
        chk("rst_w",      int'(bus.w),      0);
        chk("rst_adv",    int'(bus.adv),    0);
        chk("rst_remain", int'(bus.remain), 3);

        // 1: long dwell from reset, advance on edge 12 to x=2
        rst = 1'b0;
        cyc(3);  chk("t1_rem_e3",  int'(bus.remain), 3);
        cyc(1);  chk("t1_rem_e4",  int'(bus.remain), 2);
        cyc(4);  chk("t1_rem_e8",  int'(bus.remain), 1);
                 chk("t1_y_e8",    int'(bus.y),      0);
        cyc(3);  chk("t1_adv_e11", int'(bus.adv),    0);
        cyc(1);  chk("t1_y_e12",   int'(bus.y),      2);
                 chk("t1_rem_e12", int'(bus.remain), 3);
                 chk("t1_adv_e12", int'(bus.adv),    1);
                 chk("t1_w_e12",   int'(bus.w),      0);
        bus.x = 4'h5;
        cyc(1);  chk("t1_adv_e13", int'(bus.adv),    0);

        // 2: load odd state, then short dwell of exactly one tick
        cyc(11); chk("t2_y_e24",   int'(bus.y),      5);
                 chk("t2_adv_e24", int'(bus.adv),    1);
                 chk("t2_rem_e24", int'(bus.remain), 1);
        cyc(1);  bus.x = 4'hA;
        cyc(1);  chk("t2_adv_e26", int'(bus.adv),    0);
                 chk("t2_rem_e26", int'(bus.remain), 1);
        cyc(2);  chk("t2_y_e28",   int'(bus.y),      10);
                 chk("t2_adv_e28", int'(bus.adv),    1);
                 chk("t2_rem_e28", int'(bus.remain), 3);

        // 3: one-cycle sensor pulse, w three edges later, cleared on advance
        cyc(1);  bus.sensor = 1'b1;
        cyc(1);  bus.sensor = 1'b0;
        cyc(1);  chk("t3_w_e31",   int'(bus.w),      0);
        cyc(1);  chk("t3_w_e32",   int'(bus.w),      1);
        bus.x = 4'h3;
        cyc(7);  chk("t3_w_e39",   int'(bus.w),      1);
        cyc(1);  chk("t3_y_e40",   int'(bus.y),      3);
                 chk("t3_w_e40",   int'(bus.w),      0);

        // 4: synced rise coincides with the advance edge 44
        cyc(1);  bus.sensor = 1'b1; bus.x = 4'h6;
        cyc(2);  chk("t4_w_e43",   int'(bus.w),      0);
        cyc(1);  chk("t4_y_e44",   int'(bus.y),      6);
                 chk("t4_adv_e44", int'(bus.adv),    1);
                 chk("t4_w_e44",   int'(bus.w),      1);

        // 5: reset two cycles into the dwell aborts at once
        cyc(2);  rst = 1'b1;
        #1;      chk("t5_y",       int'(bus.y),      0);
                 chk("t5_w",       int'(bus.w),      0);
                 chk("t5_rem",     int'(bus.remain), 3);
                 chk("t5_adv",     int'(bus.adv),    0);
        bus.sensor = 1'b0;
        cyc(2);  rst = 1'b0;

        // 6: x changes every cycle; only the value at the advance edge counts
        for (int k = 1; k <= 16; k++) begin
            cyc(1);
            if (k == 3)  chk("t6_rem_e3",  int'(bus.remain), 3);
            if (k == 4)  chk("t6_rem_e4",  int'(bus.remain), 2);
            if (k == 12) begin
                chk("t6_y_e12",   int'(bus.y),      11);
                chk("t6_adv_e12", int'(bus.adv),    1);
                chk("t6_rem_e12", int'(bus.remain), 1);
            end
            if (k == 16) chk("t6_y_e16",   int'(bus.y),      15);
            bus.x = 4'(k);
        end

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cyc(1);
            bus.x = 4'($urandom);
            if ($urandom_range(7) == 0) bus.sensor = ~bus.sensor;
            if (rst) rst = ($urandom_range(2) != 0);
            else     rst = ($urandom_range(299) == 0);
        end
        rst = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
